// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, keypad
// codes and coin values.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_QTY      = 3'd2,
    ST_PAY      = 3'd3,
    ST_DISPENSE = 3'd4,
    ST_REFUND   = 3'd5
  } state_e;

  localparam logic [3:0] KEY_START   = 4'd15;
  localparam logic [3:0] KEY_CANCEL  = 4'd14;
  localparam logic [3:0] KEY_CONFIRM = 4'd13;
  localparam logic [3:0] KEY_QTY_UP  = 4'd0;
  localparam logic [3:0] KEY_QTY_DN  = 4'd1;
  localparam logic [3:0] KEY_COIN_1  = 4'd8;
  localparam logic [3:0] KEY_COIN_5  = 4'd9;
  localparam logic [3:0] KEY_COIN_10 = 4'd10;
  localparam logic [3:0] KEY_COIN_20 = 4'd11;

  localparam logic [4:0] COIN_VAL_1  = 5'd1;
  localparam logic [4:0] COIN_VAL_5  = 5'd5;
  localparam logic [4:0] COIN_VAL_10 = 5'd10;
  localparam logic [4:0] COIN_VAL_20 = 5'd20;

  function automatic logic is_coin(input logic [3:0] key);
    return key[3:2] == 2'b10;
  endfunction

  function automatic logic [4:0] coin_value(input logic [3:0] key);
    case (key)
      KEY_COIN_1:  return COIN_VAL_1;
      KEY_COIN_5:  return COIN_VAL_5;
      KEY_COIN_10: return COIN_VAL_10;
      KEY_COIN_20: return COIN_VAL_20;
      default:     return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// 4x4 active-low keypad decoder with debounce: one key_valid pulse per press,
// re-armed only after the pad has been idle for DEBOUNCE_CYC cycles.
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] c,
  input  logic [3:0] r,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

  function automatic logic one_low(input logic [3:0] v);
    logic [3:0] lo;
    lo = ~v;
    return (lo != 4'd0) && ((lo & (lo - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  logic             raw_valid;
  logic [3:0]       raw_code;
  logic [4:0]       sample;
  logic [4:0]       prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q;
  logic             key_valid_q;
  logic [3:0]       key_code_q;
  logic             stable;

  assign raw_valid = one_low(c) && one_low(r);
  assign raw_code  = {low_idx(r), low_idx(c)};
  // Invalid patterns all collapse to one "no key" value so they count as stable.
  assign sample    = raw_valid ? {1'b1, raw_code} : 5'd0;

  always_comb begin
    cnt_d = CNT_W'(1);
    if (sample == prev_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  assign stable = (cnt_d == CNT_MAX);

  // NOTE: all state here is updated with <= so every register sees the
  // pre-edge values of its neighbours, exactly like the flops being modelled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= 5'd0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      prev_q      <= sample;
      cnt_q       <= cnt_d;
      key_valid_q <= 1'b0;
      if (stable && raw_valid && armed_q) begin
        key_valid_q <= 1'b1;
        key_code_q  <= raw_code;
        armed_q     <= 1'b0;
      end else if (stable && !raw_valid) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/vending_controller.sv
// Keypad-driven vending controller: select product, quantity, pay with coins,
// then dispense with change or refund on cancel/timeout.
module vending_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned MAX_QTY      = 9,
  parameter int unsigned AMT_W        = 8,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  localparam int unsigned QTY_W       = $clog2(MAX_QTY + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    c,
  input  logic [3:0]                    r,
  input  logic [NUM_PRODUCTS*AMT_W-1:0] price_table,
  output logic [AMT_W-1:0]              view_price,
  output logic [QTY_W-1:0]              view_quantity,
  output logic [AMT_W-1:0]              view_price_q,
  output logic [AMT_W-1:0]              entered_amount,
  output logic [AMT_W-1:0]              change,
  output logic                          dispense_valid,
  output logic [2:0]                    dispense_product,
  output logic                          refund_valid,
  output logic                          error,
  output logic [2:0]                    state_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PRD_W = AMT_W + QTY_W;
  localparam logic [QTY_W-1:0] QTY_MAX = QTY_W'(MAX_QTY);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic             key_valid;
  logic [3:0]       key_code;

  keypad_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_keypad (
    .clk       (clk),
    .reset     (reset),
    .c         (c),
    .r         (r),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  state_e           state_q;
  logic [2:0]       prod_q;
  logic [AMT_W-1:0] unit_price_q, total_q, amount_q, change_q;
  logic [QTY_W-1:0] qty_q;
  logic [TMO_W-1:0] tmo_q;
  logic             dispense_valid_q, refund_valid_q, error_q;

  logic [AMT_W-1:0] prices [8];
  for (genvar i = 0; i < 8; i++) begin : g_price
    if (i < NUM_PRODUCTS) begin : g_used
      assign prices[i] = price_table[i*AMT_W +: AMT_W];
    end else begin : g_unused
      assign prices[i] = '0;
    end
  end

  logic [PRD_W-1:0] full_total;
  logic             total_fits;
  logic [AMT_W:0]   coin_sum;
  logic             busy, tmo_expired, cancel_req, sel_ok;

  assign full_total  = PRD_W'(unit_price_q) * PRD_W'(qty_q);
  assign total_fits  = (full_total >> AMT_W) == '0;
  assign coin_sum    = {1'b0, amount_q} + (AMT_W+1)'(coin_value(key_code));
  assign busy        = (state_q == ST_SELECT) || (state_q == ST_QTY) || (state_q == ST_PAY);
  assign tmo_expired = (tmo_q == TMO_LAST);
  // A key event in the expiry cycle takes priority over the timeout.
  assign cancel_req  = busy && (key_valid ? (key_code == KEY_CANCEL) : tmo_expired);
  assign sel_ok      = 32'(key_code[2:0]) < NUM_PRODUCTS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      prod_q           <= 3'd0;
      unit_price_q     <= '0;
      total_q          <= '0;
      amount_q         <= '0;
      change_q         <= '0;
      qty_q            <= '0;
      tmo_q            <= '0;
      dispense_valid_q <= 1'b0;
      refund_valid_q   <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      dispense_valid_q <= 1'b0;
      refund_valid_q   <= 1'b0;
      error_q          <= 1'b0;
      // Every non-key state change leaves the busy states or fires on expiry,
      // so clearing on those conditions also covers "reset on state change".
      tmo_q <= (key_valid || !busy || tmo_expired) ? '0 : tmo_q + TMO_W'(1);

      if (state_q == ST_PAY && amount_q >= total_q) begin
        state_q          <= ST_DISPENSE;
        dispense_valid_q <= 1'b1;
        change_q         <= amount_q - total_q;
      end else if (cancel_req) begin
        state_q        <= ST_REFUND;
        refund_valid_q <= 1'b1;
        change_q       <= amount_q;
      end else begin
        case (state_q)
          ST_IDLE: if (key_valid && key_code == KEY_START) begin
            state_q      <= ST_SELECT;
            amount_q     <= '0;
            unit_price_q <= '0;
            qty_q        <= '0;
            total_q      <= '0;
          end
          ST_SELECT: if (key_valid && !key_code[3]) begin
            if (sel_ok) begin
              prod_q       <= key_code[2:0];
              unit_price_q <= prices[key_code[2:0]];
              qty_q        <= QTY_W'(1);
              state_q      <= ST_QTY;
            end else begin
              error_q <= 1'b1;
            end
          end
          ST_QTY: if (key_valid) begin
            if (key_code == KEY_QTY_UP && qty_q != QTY_MAX) begin
              qty_q <= qty_q + QTY_W'(1);
            end else if (key_code == KEY_QTY_DN && qty_q > QTY_W'(1)) begin
              qty_q <= qty_q - QTY_W'(1);
            end else if (key_code == KEY_CONFIRM) begin
              if (total_fits) begin
                total_q <= full_total[AMT_W-1:0];
                state_q <= ST_PAY;
              end else begin
                error_q <= 1'b1;
              end
            end
          end
          ST_PAY: if (key_valid && is_coin(key_code)) begin
            if (coin_sum[AMT_W]) begin
              error_q <= 1'b1;
            end else begin
              amount_q <= coin_sum[AMT_W-1:0];
            end
          end
          ST_DISPENSE, ST_REFUND: begin
            state_q  <= ST_IDLE;
            amount_q <= '0;
            change_q <= '0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign view_price       = unit_price_q;
  assign view_quantity    = qty_q;
  assign view_price_q     = total_q;
  assign entered_amount   = amount_q;
  assign change           = change_q;
  assign dispense_valid   = dispense_valid_q;
  assign dispense_product = prod_q;
  assign refund_valid     = refund_valid_q;
  assign error            = error_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: purchase, overpay, overflow, cancel,
// timeout, key bounce and mid-transaction reset.
module tb_vending_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  c, r;
  logic [31:0] price_table;
  logic [7:0]  view_price, view_price_q, entered_amount, change;
  logic [3:0]  view_quantity;
  logic        dispense_valid, refund_valid, error;
  logic [2:0]  dispense_product, state_o;

  vending_controller #(
    .NUM_PRODUCTS (4),
    .MAX_QTY      (9),
    .AMT_W        (8),
    .DEBOUNCE_CYC (2),
    .TIMEOUT_CYC  (50)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .c                (c),
    .r                (r),
    .price_table      (price_table),
    .view_price       (view_price),
    .view_quantity    (view_quantity),
    .view_price_q     (view_price_q),
    .entered_amount   (entered_amount),
    .change           (change),
    .dispense_valid   (dispense_valid),
    .dispense_product (dispense_product),
    .refund_valid     (refund_valid),
    .error            (error),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_disp  = 0;
  int n_refund = 0;
  int n_err   = 0;
  logic [7:0] last_change = 8'd0;
  logic [2:0] last_prod   = 3'd0;

  // Pulse monitor, sampled on the falling edge away from state updates.
  always @(negedge clk) begin
    if (dispense_valid) begin
      n_disp++;
      last_change = change;
      last_prod   = dispense_product;
    end
    if (refund_valid) begin
      n_refund++;
      last_change = change;
    end
    if (error) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    c = ~(4'b0001 << k[1:0]);
    r = ~(4'b0001 << k[3:2]);
    repeat (4) @(negedge clk);
    c = 4'hF;
    r = 4'hF;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    price_table = {8'd200, 8'd7, 8'd30, 8'd15};
    c = 4'hF;
    r = 4'hF;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state",   32'(state_o), 32'd0);
    check("rst_price",   32'(view_price), 32'd0);
    check("rst_qty",     32'(view_quantity), 32'd0);
    check("rst_total",   32'(view_price_q), 32'd0);
    check("rst_amount",  32'(entered_amount), 32'd0);
    check("rst_change",  32'(change), 32'd0);
    check("rst_pulses",  32'({dispense_valid, refund_valid, error}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // One-cycle bounce of START and a two-low-bit column pattern: no event.
    c = 4'b0111; r = 4'b0111;
    @(negedge clk);
    c = 4'hF; r = 4'hF;
    repeat (8) @(negedge clk);
    check("bounce_idle", 32'(state_o), 32'd0);
    c = 4'b0011; r = 4'b0111;
    repeat (6) @(negedge clk);
    c = 4'hF; r = 4'hF;
    repeat (6) @(negedge clk);
    check("multibit_idle", 32'(state_o), 32'd0);

    // Purchase: product 0 (15) x3 = 45, pay 20+20+5.
    press(4'd15);
    check("start_select", 32'(state_o), 32'd1);
    check("start_amount", 32'(entered_amount), 32'd0);
    press(4'd5);
    check("badprod_err",   32'(n_err), 32'd1);
    check("badprod_state", 32'(state_o), 32'd1);
    press(4'd0);
    check("sel_state", 32'(state_o), 32'd2);
    check("sel_price", 32'(view_price), 32'd15);
    check("sel_qty",   32'(view_quantity), 32'd1);
    press(4'd0);
    press(4'd0);
    check("qty_up", 32'(view_quantity), 32'd3);
    press(4'd13);
    check("confirm_state", 32'(state_o), 32'd3);
    check("confirm_total", 32'(view_price_q), 32'd45);
    press(4'd11);
    press(4'd11);
    check("pay_amount",  32'(entered_amount), 32'd40);
    check("pay_no_disp", 32'(n_disp), 32'd0);
    press(4'd9);
    check("buy_disp",   32'(n_disp), 32'd1);
    check("buy_change", 32'(last_change), 32'd0);
    check("buy_prod",   32'(last_prod), 32'd0);
    check("buy_idle",   32'(state_o), 32'd0);
    check("buy_clear",  32'(entered_amount), 32'd0);
    check("buy_hold",   32'(view_price_q), 32'd45);

    // Overpay: product 2 (7) x1, coin 10 -> change 3.
    press(4'd15);
    press(4'd2);
    press(4'd13);
    press(4'd10);
    check("over_disp",   32'(n_disp), 32'd2);
    check("over_change", 32'(last_change), 32'd3);
    check("over_prod",   32'(last_prod), 32'd2);

    // Overflow: product 3 (200) x2 = 400 does not fit in 8 bits.
    press(4'd15);
    press(4'd3);
    press(4'd0);
    check("ovf_qty", 32'(view_quantity), 32'd2);
    press(4'd13);
    check("ovf_err",   32'(n_err), 32'd2);
    check("ovf_state", 32'(state_o), 32'd2);
    press(4'd1);
    press(4'd1);
    check("qty_floor",     32'(view_quantity), 32'd1);
    check("qty_floor_err", 32'(n_err), 32'd2);
    press(4'd14);
    check("ovf_refund", 32'(n_refund), 32'd1);
    check("ovf_rchg",   32'(last_change), 32'd0);

    // Cancel after 5+5 in PAY.
    press(4'd15);
    press(4'd1);
    press(4'd13);
    press(4'd9);
    press(4'd9);
    check("cancel_amount", 32'(entered_amount), 32'd10);
    press(4'd14);
    check("cancel_refund", 32'(n_refund), 32'd2);
    check("cancel_change", 32'(last_change), 32'd10);
    check("cancel_idle",   32'(state_o), 32'd0);
    check("cancel_clear",  32'(entered_amount), 32'd0);

    // Timeout after 5+5 in PAY.
    press(4'd15);
    press(4'd1);
    press(4'd13);
    press(4'd9);
    press(4'd9);
    repeat (30) @(negedge clk);
    check("tmo_early_state",  32'(state_o), 32'd3);
    check("tmo_early_refund", 32'(n_refund), 32'd2);
    for (int i = 0; i < 60 && n_refund < 3; i++) @(negedge clk);
    check("tmo_refund", 32'(n_refund), 32'd3);
    check("tmo_change", 32'(last_change), 32'd10);
    @(negedge clk);
    check("tmo_idle", 32'(state_o), 32'd0);

    // Asynchronous reset in PAY: everything clears at once, no pulses.
    press(4'd15);
    press(4'd0);
    press(4'd13);
    press(4'd9);
    check("prerst_state",  32'(state_o), 32'd3);
    check("prerst_amount", 32'(entered_amount), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("arst_state",  32'(state_o), 32'd0);
    check("arst_amount", 32'(entered_amount), 32'd0);
    check("arst_price",  32'(view_price), 32'd0);
    check("arst_qty",    32'(view_quantity), 32'd0);
    check("arst_total",  32'(view_price_q), 32'd0);
    check("arst_change", 32'(change), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("arst_no_disp",   32'(n_disp), 32'd2);
    check("arst_no_refund", 32'(n_refund), 32'd3);
    check("arst_idle",      32'(state_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameters SHALL be:
- NUM_PRODUCTS, default 4, number of products, legal range 1..8.
- MAX_QTY, default 9, maximum quantity per purchase.
- AMT_W, default 8, width of all money values.
- DEBOUNCE_CYC, default 4, cycles a key must be stable.
- TIMEOUT_CYC, default 1000, idle cycles before auto-cancel.
REQ-002 Ports SHALL be, one clock; reset is asynchronous and active-high:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- c  in  4  keypad column lines, active-low.
- r  in  4  keypad row lines, active-low.
- price_table  in  NUM_PRODUCTS*AMT_W  unit prices; product i at bits [i*AMT_W +: AMT_W].
- view_price  out  AMT_W  unit price of the selected product.
- view_quantity  out  QTY_W=$clog2(MAX_QTY+1)  selected quantity.
- view_price_q  out  AMT_W  total price, unit price x quantity.
- entered_amount  out  AMT_W  money inserted so far.
- change  out  AMT_W  change or refund value; valid while dispense_valid or refund_valid is high.
- dispense_valid  out  1  one-cycle pulse when the product is dispensed.
- dispense_product  out  3  index of the dispensed product.
- refund_valid  out  1  one-cycle pulse when money is refunded.
- error  out  1  one-cycle pulse when an input is rejected.
- state_o  out  3  current state encoding.

Function
REQ-003 A key SHALL be valid only when c has exactly one low bit and r has exactly one low bit.
- Key code = 4*row_idx + col_idx, where the index is the position of the low bit.
- Any other pattern SHALL count as "no key".
REQ-004 A key event SHALL pulse for one cycle after the same valid code has been stable for DEBOUNCE_CYC consecutive cycles.
- No further event SHALL occur until "no key" has been stable for DEBOUNCE_CYC cycles.
REQ-005 Key map:
- 15 = START; 14 = CANCEL; 13 = CONFIRM.
- 0..7 = product select (SELECT state only).
- 0 = qty+1 and 1 = qty-1 (QTY state only).
- 8/9/10/11 = coins of value 1/5/10/20 (PAY state only).
- Keys not listed for the current state SHALL be ignored, with no error.
REQ-006 State machine: IDLE, SELECT, QTY, PAY, DISPENSE, REFUND.
REQ-007 IDLE->SELECT on START; entered_amount SHALL clear to 0.
REQ-008 In SELECT, key k < NUM_PRODUCTS SHALL:
- latch k;
- set view_price to price k and view_quantity to 1;
- go to QTY.
Key k >= NUM_PRODUCTS (k <= 7) SHALL pulse error and stay in SELECT.
REQ-009 In QTY, qty+1 and qty-1 SHALL saturate in the range [1, MAX_QTY], with no error at the limits.
REQ-010 view_price_q SHALL be computed at full width each cycle in QTY. On CONFIRM:
- If the product is at most 2^AMT_W-1, latch it into view_price_q and go to PAY.
- Otherwise pulse error and stay in QTY.
REQ-011 In PAY, a coin SHALL add its value to entered_amount. A coin that would overflow AMT_W SHALL be rejected, pulse error, and leave the amount unchanged.
REQ-012 When entered_amount >= view_price_q (checked the cycle after the update), the FSM SHALL go to DISPENSE.
REQ-013 DISPENSE SHALL last exactly one cycle:
- dispense_valid=1, dispense_product = latched index, change = entered_amount - view_price_q.
- Next state is IDLE.
REQ-014 CANCEL in SELECT, QTY or PAY SHALL go to REFUND.
- REFUND lasts one cycle: refund_valid=1, change = entered_amount.
- Next state is IDLE.
REQ-015 The timeout counter SHALL:
- reset on every key event and on each state change;
- in SELECT, QTY or PAY, after TIMEOUT_CYC cycles with no event, behave exactly like CANCEL.
REQ-016 On return to IDLE, entered_amount SHALL clear. view_price, view_quantity and view_price_q SHALL hold until the next START.
REQ-017 A key event and a timeout in the same cycle: the key event SHALL win.

Reset
REQ-018 Reset SHALL force state IDLE and clear all outputs, debounce counters and timeout counters to 0, immediately and asynchronously.
REQ-019 Reset asserted mid-transaction SHALL produce no dispense_valid or refund_valid pulse.

Structure
REQ-020 Package vend_pkg SHALL hold the state enum, the key-code constants and the coin-value constants.
REQ-021 Sub-module keypad_debounce SHALL implement REQ-003/004 and output key_valid and key_code[3:0].

Verification
Defaults throughout: DEBOUNCE_CYC=2, TIMEOUT_CYC=50, prices {15,30,7,200}.
REQ-022 Purchase: START, key0, qty+1 x2, CONFIRM, coins 20+20 -> view_price_q=45; dispense_valid with dispense_product=0 and change=0 after the 3rd coin (a 5 added).
REQ-023 Overpay: product 2, qty 1, coin 10 -> change=3, single dispense_valid pulse.
REQ-024 Overflow: product 3, qty 2 -> CONFIRM pulses error and the state stays QTY; qty-1 at qty=1 stays 1 with no error.
REQ-025 Cancel/timeout: coins 5+5 then CANCEL -> refund_valid with change=10. Second run: no key for 50 cycles in PAY -> identical refund.
REQ-026 Bounce and reset: key toggled for 1 cycle -> no event; multi-bit c=0011 -> ignored; reset in PAY -> IDLE, all outputs 0, no pulses.
